fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the control unit.
- Owns the program counter (PC) and the instruction register (IR), reads instruction memory, and splits the 15-bit instruction into opcode [14:8] and literal [7:0].
- Produces instr_valid, a one-cycle execute strobe that downstream must use to qualify control-unit writes (L_A, L_B, D_W).
- Consumes the control unit's L_PC to take jumps.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/pc_reg.sv | 25 ++
 rtl/fetch_unit.sv | 161 ++++++++++++++++
 tb/tb_fetch_unit.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU front end: fetch FSM states, instruction
// field positions and default widths.
package cpu_pkg;

  localparam int PC_WIDTH    = 8;
  localparam int INSTR_WIDTH = 15;

  // Instruction field positions: opcode [14:8], literal [7:0].
  localparam int OPCODE_MSB = 14;
  localparam int OPCODE_LSB = 8;
  localparam int LIT_MSB    = 7;

  // Opcode that stops the fetch unit until reset.
  localparam logic [6:0] HALT_OPCODE = 7'b1111111;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    EXEC  = 3'd3,
    HALT  = 3'd4
  } state_t;

endpackage

// File: rtl/pc_reg.sv
// Program counter register: load has priority over increment, otherwise hold.
// Increment wraps naturally modulo 2^WIDTH.
module pc_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             inc,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] pc
);

  // PC update: async clear, then load / increment / hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + WIDTH'(1);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns PC and IR, reads instruction memory and
// presents opcode/literal plus a one-cycle execute strobe to the control unit.
//
// Strobe protocol: there is no backpressure. instr_valid is high for exactly
// the one EXEC cycle of each non-halt instruction; opcode/literal are stable
// for that whole cycle and downstream qualifies every side effect (L_A, L_B,
// D_W) with it. L_PC/jump_addr are only looked at during that same cycle.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int         PC_WIDTH    = cpu_pkg::PC_WIDTH,
  parameter int         INSTR_WIDTH = cpu_pkg::INSTR_WIDTH,
  parameter int         ROM_LATENCY = 1,
  parameter logic [6:0] HALT_OPCODE = cpu_pkg::HALT_OPCODE
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   run,
  input  logic                   step,
  input  logic                   L_PC,
  input  logic [PC_WIDTH-1:0]    jump_addr,
  output logic [PC_WIDTH-1:0]    imem_addr,
  output logic                   imem_rd,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  output logic [6:0]             opcode,
  output logic [7:0]             literal,
  output logic                   instr_valid,
  output logic [PC_WIDTH-1:0]    pc,
  output logic                   halted,
  output state_t                 state_dbg
);

  // Counter reload value: number of WAIT cycles minus one.
  localparam logic [1:0] LAT_M1 = (ROM_LATENCY > 0) ? 2'(ROM_LATENCY - 1) : 2'd0;

  state_t                 state_q, state_d;
  logic [1:0]             cnt_q;
  logic                   single_q;
  logic [INSTR_WIDTH-1:0] ir_q;

  logic ir_load, cnt_load, cnt_dec, single_set, single_clr;
  logic pc_load, pc_inc;

  assign opcode    = ir_q[OPCODE_MSB:OPCODE_LSB];
  assign literal   = ir_q[LIT_MSB:0];
  assign imem_addr = pc;
  assign state_dbg = state_q;

  pc_reg #(
    .WIDTH(PC_WIDTH)
  ) u_pc_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (pc_load),
    .inc     (pc_inc),
    .load_val(jump_addr),
    .pc      (pc)
  );

  // Next-state and control decode for the fetch FSM.
  always_comb begin
    state_d     = state_q;
    ir_load     = 1'b0;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    single_set  = 1'b0;
    single_clr  = 1'b0;
    pc_load     = 1'b0;
    pc_inc      = 1'b0;
    imem_rd     = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;
    case (state_q)
      IDLE: begin
        // run has priority; a step only arms single-shot when run is low.
        if (run) begin
          state_d = FETCH;
        end else if (step) begin
          state_d    = FETCH;
          single_set = 1'b1;
        end
      end
      FETCH: begin
        imem_rd = 1'b1;
        if (ROM_LATENCY == 0) begin
          ir_load = 1'b1;
          state_d = EXEC;
        end else begin
          cnt_load = 1'b1;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 2'd0) begin
          ir_load = 1'b1;
          state_d = EXEC;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      EXEC: begin
        if (opcode == HALT_OPCODE) begin
          state_d = HALT;
        end else begin
          instr_valid = 1'b1;
          pc_load     = L_PC;
          pc_inc      = ~L_PC;
          single_clr  = 1'b1;
          state_d     = (run && !single_q) ? FETCH : IDLE;
        end
      end
      HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Memory latency counter: loaded in FETCH, counts down through WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 2'd0;
    end else if (cnt_load) begin
      cnt_q <= LAT_M1;
    end else if (cnt_dec) begin
      cnt_q <= cnt_q - 2'd1;
    end
  end

  // Single-shot flag: remembers that this instruction was started by step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      single_q <= 1'b0;
    end else if (single_set) begin
      single_q <= 1'b1;
    end else if (single_clr) begin
      single_q <= 1'b0;
    end
  end

  // Instruction register: captures memory data when it becomes valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_q <= '0;
    end else if (ir_load) begin
      ir_q <= imem_data;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit with a one-cycle-latency instruction ROM.
module tb_fetch_unit;
  import cpu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic        step;
  logic        L_PC;
  logic [7:0]  jump_addr;
  logic [7:0]  imem_addr;
  logic        imem_rd;
  logic [14:0] imem_data;
  logic [6:0]  opcode;
  logic [7:0]  literal;
  logic        instr_valid;
  logic [7:0]  pc;
  logic        halted;
  state_t      state_dbg;

  logic [14:0] mem [256];

  int checks = 0;
  int errors = 0;

  // Clock and DUT
  initial clk = 1'b0;
  always #5 clk = ~clk;

  fetch_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .step       (step),
    .L_PC       (L_PC),
    .jump_addr  (jump_addr),
    .imem_addr  (imem_addr),
    .imem_rd    (imem_rd),
    .imem_data  (imem_data),
    .opcode     (opcode),
    .literal    (literal),
    .instr_valid(instr_valid),
    .pc         (pc),
    .halted     (halted),
    .state_dbg  (state_dbg)
  );

  // ROM model: data appears one cycle after the read strobe.
  always @(posedge clk) begin
    if (imem_rd) imem_data <= mem[imem_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance until instr_valid, bounded; returns cycles taken (0 on timeout).
  task automatic wait_valid(output int cyc);
    cyc = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (instr_valid === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  initial begin
    int cyc;
    int bad;
    logic [6:0] exp_op [3];
    logic [7:0] exp_lit [3];
    exp_op[0] = 7'h00; exp_op[1] = 7'h2C; exp_op[2] = 7'h30;
    exp_lit[0] = 8'h00; exp_lit[1] = 8'h05; exp_lit[2] = 8'h03;

    rst_n = 1'b0; run = 1'b0; step = 1'b0; L_PC = 1'b0; jump_addr = 8'h00;
    imem_data = '0;
    for (int i = 0; i < 256; i++) mem[i] = 15'h0000;
    mem[8'h00] = 15'h0000;
    mem[8'h01] = 15'h2C05;
    mem[8'h02] = 15'h3003;
    mem[8'h03] = 15'h0001;
    mem[8'h04] = 15'h0520;
    mem[8'h20] = 15'h1234;
    mem[8'h21] = 15'h0A0B;
    mem[8'h22] = 15'h0000;
    mem[8'h40] = 15'h7F00;
    mem[8'hFF] = 15'h0177;

    // Reset values
    repeat (2) tick();
    chk("rst_pc", 32'(pc), 32'h00);
    chk("rst_opcode", 32'(opcode), 32'h00);
    chk("rst_literal", 32'(literal), 32'h00);
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_rd", 32'(imem_rd), 32'h0);
    chk("rst_addr", 32'(imem_addr), 32'h00);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_state", 32'(state_dbg), 32'(IDLE));

    // Continuous run: three instructions, one every three cycles
    rst_n = 1'b1;
    run   = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_valid(cyc);
      chk($sformatf("run%0d_period", k), 32'(cyc), 32'd3);
      chk($sformatf("run%0d_opcode", k), 32'(opcode), 32'(exp_op[k]));
      chk($sformatf("run%0d_literal", k), 32'(literal), 32'(exp_lit[k]));
      chk($sformatf("run%0d_pc", k), 32'(pc), 32'(k));
    end

    // L_PC outside EXEC must not move the PC
    tick();
    chk("pc3_fetch", 32'(pc), 32'h03);
    L_PC = 1'b1; jump_addr = 8'h55;
    tick();
    chk("lpc_fetch_pc", 32'(pc), 32'h03);
    tick();
    L_PC = 1'b0;
    chk("lpc_wait_pc", 32'(pc), 32'h03);
    chk("i3_valid", 32'(instr_valid), 32'h1);
    chk("i3_literal", 32'(literal), 32'h01);
    tick();
    chk("i3_next_pc", 32'(pc), 32'h04);

    // Jump taken in EXEC
    repeat (2) tick();
    chk("i4_valid", 32'(instr_valid), 32'h1);
    chk("i4_opcode", 32'(opcode), 32'h05);
    L_PC = 1'b1; jump_addr = 8'h20;
    tick();
    L_PC = 1'b0;
    chk("jump_pc", 32'(pc), 32'h20);
    chk("jump_addr", 32'(imem_addr), 32'h20);
    chk("jump_rd", 32'(imem_rd), 32'h1);
    repeat (2) tick();
    chk("i20_opcode", 32'(opcode), 32'h12);
    chk("i20_literal", 32'(literal), 32'h34);
    chk("i20_valid", 32'(instr_valid), 32'h1);

    // run falls during EXEC: finish and go idle
    run = 1'b0;
    tick();
    chk("stop_state", 32'(state_dbg), 32'(IDLE));
    chk("stop_pc", 32'(pc), 32'h21);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (instr_valid !== 1'b0 || imem_rd !== 1'b0) bad++;
    end
    chk("idle_quiet", 32'(bad), 32'd0);

    // Single step; a step during WAIT is ignored
    step = 1'b1;
    tick();
    step = 1'b0;
    chk("step_state", 32'(state_dbg), 32'(FETCH));
    chk("step_addr", 32'(imem_addr), 32'h21);
    tick();
    step = 1'b1;
    tick();
    step = 1'b0;
    chk("step_valid", 32'(instr_valid), 32'h1);
    chk("step_opcode", 32'(opcode), 32'h0A);
    chk("step_literal", 32'(literal), 32'h0B);
    tick();
    chk("step_pc", 32'(pc), 32'h22);
    chk("step_idle", 32'(state_dbg), 32'(IDLE));
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (instr_valid !== 1'b0 || imem_rd !== 1'b0) bad++;
    end
    chk("step_once", 32'(bad), 32'd0);
    chk("step_pc_hold", 32'(pc), 32'h22);

    // run and step together: run wins, execution continues; PC wrap
    run = 1'b1; step = 1'b1;
    tick();
    step = 1'b0;
    repeat (2) tick();
    chk("rs_valid", 32'(instr_valid), 32'h1);
    L_PC = 1'b1; jump_addr = 8'hFF;
    tick();
    L_PC = 1'b0;
    chk("rs_continues", 32'(state_dbg), 32'(FETCH));
    chk("ff_pc", 32'(pc), 32'hFF);
    repeat (2) tick();
    chk("ff_valid", 32'(instr_valid), 32'h1);
    chk("ff_literal", 32'(literal), 32'h77);
    tick();
    chk("wrap_pc", 32'(pc), 32'h00);
    chk("wrap_addr", 32'(imem_addr), 32'h00);

    // Jump to the halt instruction
    repeat (2) tick();
    chk("w0_valid", 32'(instr_valid), 32'h1);
    L_PC = 1'b1; jump_addr = 8'h40;
    tick();
    L_PC = 1'b0;
    chk("h_pc", 32'(pc), 32'h40);
    repeat (2) tick();
    chk("h_exec_state", 32'(state_dbg), 32'(EXEC));
    chk("h_exec_valid", 32'(instr_valid), 32'h0);
    chk("h_exec_opcode", 32'(opcode), 32'h7F);
    L_PC = 1'b1; jump_addr = 8'h99;
    tick();
    chk("h_halted", 32'(halted), 32'h1);
    chk("h_pc_frozen", 32'(pc), 32'h40);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      run  = i[0];
      step = i[1];
      tick();
      if (imem_rd !== 1'b0 || instr_valid !== 1'b0 || halted !== 1'b1 || pc !== 8'h40) bad++;
    end
    chk("h_sticky", 32'(bad), 32'd0);
    L_PC = 1'b0; run = 1'b0; step = 1'b0;

    // Asynchronous reset out of HALT
    #3 rst_n = 1'b0;
    #1;
    chk("hr_halted", 32'(halted), 32'h0);
    chk("hr_pc", 32'(pc), 32'h00);
    chk("hr_opcode", 32'(opcode), 32'h00);
    chk("hr_state", 32'(state_dbg), 32'(IDLE));

    // Reset asserted mid-WAIT with pc=0x07
    rst_n = 1'b1; run = 1'b1;
    repeat (3) tick();
    chk("r7_valid", 32'(instr_valid), 32'h1);
    L_PC = 1'b1; jump_addr = 8'h07;
    tick();
    L_PC = 1'b0;
    chk("r7_pc", 32'(pc), 32'h07);
    tick();
    chk("r7_wait", 32'(state_dbg), 32'(WAIT));
    #3 rst_n = 1'b0;
    #1;
    chk("mr_pc", 32'(pc), 32'h00);
    chk("mr_addr", 32'(imem_addr), 32'h00);
    chk("mr_rd", 32'(imem_rd), 32'h0);
    chk("mr_valid", 32'(instr_valid), 32'h0);
    chk("mr_state", 32'(state_dbg), 32'(IDLE));
    tick();
    #2 rst_n = 1'b1;
    tick();
    chk("rel_state", 32'(state_dbg), 32'(FETCH));
    chk("rel_rd", 32'(imem_rd), 32'h1);
    chk("rel_addr", 32'(imem_addr), 32'h00);
    wait_valid(cyc);
    chk("rel_period", 32'(cyc), 32'd2);
    chk("rel_pc", 32'(pc), 32'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
